// File: rtl/request_encoder_pkg.sv
// Shared constants and types for the round-robin 4-to-2 request encoder.
package request_encoder_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef logic [IDX_W-1:0] idx_t;

  // Pointer value after reset: the search then begins at index 0.
  localparam idx_t RESET_LAST = 2'd3;

  function automatic logic [NUM_REQ-1:0] idx_onehot(input idx_t idx);
    logic [NUM_REQ-1:0] one;
    one = 1;
    return one << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating search: first set bit of cand after start, wrapping mod 4.
module rr_pick4
  import request_encoder_pkg::*;
(
  input  logic [NUM_REQ-1:0] cand,
  input  idx_t               start,
  output idx_t               idx,
  output logic               found
);

  idx_t probe;

  // Probe order is start+1 .. start+4; the last probe wraps back to start itself.
  always_comb begin
    idx   = start;
    found = 1'b0;
    probe = start;
    for (int k = 1; k <= NUM_REQ; k++) begin
      probe = start + idx_t'(k);
      if (!found && cand[probe]) begin
        idx   = probe;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/request_encoder.sv
// Round-robin 4-to-2 request encoder: registered {address1,address0,enable}
// with a ready handshake and a combinational one-hot ack to the winner.
module request_encoder
  import request_encoder_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ready,
  output logic               address0,
  output logic               address1,
  output logic               enable,
  output logic [NUM_REQ-1:0] ack
);

  logic               en_q, en_d;
  idx_t               addr_q, addr_d;
  idx_t               last_q, last_d;
  logic               load;
  logic [NUM_REQ-1:0] cand;
  idx_t               start;
  idx_t               pick_idx;
  logic               pick_found;

  assign ack  = (en_q && ready) ? idx_onehot(addr_q) : '0;
  assign load = !en_q || ready;

  // The index being accepted this cycle still has req high; mask it out.
  assign cand  = req & ~ack;
  assign start = ROUND_ROBIN ? last_q : RESET_LAST;

  rr_pick4 u_pick (
    .cand  (cand),
    .start (start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    en_d   = en_q;
    addr_d = addr_q;
    last_d = last_q;
    if (load) begin
      if (pick_found) begin
        en_d   = 1'b1;
        addr_d = pick_idx;
        last_d = pick_idx;
      end else begin
        en_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      last_q <= RESET_LAST;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
      last_q <= last_d;
    end
  end

  assign address0 = addr_q[0];
  assign address1 = addr_q[1];
  assign enable   = en_q;

endmodule

// File: tb/tb_request_encoder.sv
// Bench for request_encoder: two instances (round-robin and fixed priority)
// checked every cycle against a queue-free behavioural arbiter model.
module tb_request_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ready;
  logic [3:0] req_rr, req_fx;
  logic       a0_rr, a1_rr, en_rr, a0_fx, a1_fx, en_fx;
  logic [3:0] ack_rr, ack_fx;

  request_encoder #(.ROUND_ROBIN(1'b1)) u_dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req_rr), .ready(ready),
    .address0(a0_rr), .address1(a1_rr), .enable(en_rr), .ack(ack_rr)
  );

  request_encoder #(.ROUND_ROBIN(1'b0)) u_dut_fx (
    .clk(clk), .rst_n(rst_n), .req(req_fx), .ready(ready),
    .address0(a0_fx), .address1(a1_fx), .enable(en_fx), .ack(ack_fx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state per instance: 0 = round-robin, 1 = fixed priority.
  int         m_en[2];
  int         m_addr[2];
  int         m_last[2];
  logic [3:0] acked[2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] get_req(input int d);
    return (d == 0) ? req_rr : req_fx;
  endfunction

  task automatic set_req(input int d, input logic [3:0] v);
    if (d == 0) req_rr = v;
    else        req_fx = v;
  endtask

  function automatic int act_en(input int d);
    return (d == 0) ? int'(en_rr) : int'(en_fx);
  endfunction

  function automatic int act_addr(input int d);
    return (d == 0) ? int'({a1_rr, a0_rr}) : int'({a1_fx, a0_fx});
  endfunction

  function automatic int act_ack(input int d);
    return (d == 0) ? int'(ack_rr) : int'(ack_fx);
  endfunction

  function automatic logic [3:0] exp_ack(input int d);
    logic [3:0] one;
    one = 4'b0001;
    if (m_en[d] != 0 && ready) return one << m_addr[d];
    return 4'b0000;
  endfunction

  // Winner by the stated search order; -1 when nothing is eligible.
  function automatic int search(input int d, input logic [3:0] cand);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (d == 0) ? (m_last[d] + k) % 4 : k - 1;
      if (cand[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_en[d]   = 0;
      m_addr[d] = 0;
      m_last[d] = 3;
      acked[d]  = 4'b0000;
    end
  endtask

  task automatic compare_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s.d%0d.enable", tag, d), act_en(d), m_en[d]);
      check($sformatf("%s.d%0d.address", tag, d), act_addr(d), m_addr[d]);
      check($sformatf("%s.d%0d.ack", tag, d), act_ack(d), int'(exp_ack(d)));
    end
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step(input string tag);
    int         nen[2], naddr[2], nlast[2];
    logic [3:0] ack_e;
    int         p;
    #1;
    compare_all(tag);
    for (int d = 0; d < 2; d++) begin
      ack_e    = exp_ack(d);
      acked[d] = ack_e;
      nen[d]   = m_en[d];
      naddr[d] = m_addr[d];
      nlast[d] = m_last[d];
      if (m_en[d] == 0 || ready) begin
        p = search(d, get_req(d) & ~ack_e);
        if (p >= 0) begin
          nen[d]   = 1;
          naddr[d] = p;
          nlast[d] = p;
        end else begin
          nen[d] = 0;
        end
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      m_en[d]   = nen[d];
      m_addr[d] = naddr[d];
      m_last[d] = nlast[d];
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) set_req(d, get_req(d) & ~acked[d]);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s.rst.d%0d.enable", tag, d), act_en(d), 0);
      check($sformatf("%s.rst.d%0d.address", tag, d), act_addr(d), 0);
      check($sformatf("%s.rst.d%0d.ack", tag, d), act_ack(d), 0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_both(input logic [3:0] v);
    req_rr = v;
    req_fx = v;
  endtask

  logic [3:0] hold_pat[3];

  initial begin
    hold_pat[0] = 4'b1000;
    hold_pat[1] = 4'b0001;
    hold_pat[2] = 4'b0000;
    rst_n = 1'b0;
    ready = 1'b0;
    set_both(4'b0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle with all requests high.
    set_both(4'b1111);
    ready = 1'b1;
    step("t1");
    do_reset("t1");

    // Single request, then withdrawal after ack.
    set_both(4'b0100);
    ready = 1'b1;
    step("t2a");
    check("t2.enable", int'(en_rr), 1);
    check("t2.address", int'({a1_rr, a0_rr}), 2);
    check("t2.ack", int'(ack_rr), 4'b0100);
    step("t2b");
    check("t2.enable_drop", int'(en_rr), 0);
    check("t2.address_hold", int'({a1_rr, a0_rr}), 2);
    check("t2.ack_drop", int'(ack_rr), 0);

    // Full rotation from the reset pointer.
    do_reset("t3");
    set_both(4'b1111);
    ready = 1'b1;
    step("t3");
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3.rr.address%0d", k), int'({a1_rr, a0_rr}), k);
      check($sformatf("t3.fx.address%0d", k), int'({a1_fx, a0_fx}), k);
      check($sformatf("t3.rr.ack%0d", k), int'(ack_rr), 1 << k);
      step("t3");
    end
    check("t3.rr.enable_end", int'(en_rr), 0);
    check("t3.fx.enable_end", int'(en_fx), 0);

    // Backpressure: grant holds while req wanders.
    do_reset("t4");
    set_both(4'b0010);
    ready = 1'b1;
    step("t4");
    ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_both(hold_pat[c % 3]);
      step("t4");
      check("t4.address_hold", int'({a1_rr, a0_rr}), 1);
      check("t4.enable_hold", int'(en_rr), 1);
      check("t4.ack_hold", int'(ack_rr), 0);
    end
    ready = 1'b1;
    set_both(4'b0000);
    #1;
    check("t4.rr.ack_release", int'(ack_rr), 4'b0010);
    check("t4.fx.ack_release", int'(ack_fx), 4'b0010);
    step("t4");

    // Fairness between req0 and req3 re-asserted after every ack.
    do_reset("t5");
    set_both(4'b1001);
    ready = 1'b1;
    step("t5");
    for (int k = 0; k < 8; k++) begin
      check("t5.rr.address", int'({a1_rr, a0_rr}), (k % 2) ? 3 : 0);
      check("t5.fx.address", int'({a1_fx, a0_fx}), (k % 2) ? 3 : 0);
      req_rr = req_rr | 4'b1001;
      req_fx = req_fx | 4'b1001;
      step("t5");
    end

    // Reset while a grant is held under backpressure.
    do_reset("t6");
    set_both(4'b0100);
    ready = 1'b0;
    step("t6");
    check("t6.enable_held", int'(en_rr), 1);
    check("t6.address_held", int'({a1_rr, a0_rr}), 2);
    do_reset("t6");
    set_both(4'b1010);
    ready = 1'b1;
    step("t6");
    check("t6.rr.first_grant", int'({a1_rr, a0_rr}), 1);
    check("t6.fx.first_grant", int'({a1_fx, a0_fx}), 1);
    check("t6.rr.enable", int'(en_rr), 1);

    // Randomized traffic, requests held until acked.
    do_reset("rand");
    for (int n = 0; n < 800; n++) begin
      ready = ($urandom_range(0, 3) != 0);
      for (int d = 0; d < 2; d++)
        set_req(d, get_req(d) | (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15))));
      if (n == 400) do_reset("rand");
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/request_encoder.md
Name: request_encoder

Overview:
- Round-robin 4-to-2 request encoder: the inverse of the 2-to-4 address decoder.
- Collects up to four level-sensitive request lines and selects one per transfer.
- Presents the winner as a registered address0/address1/enable triple with a ready handshake, so the outputs connect directly to the decoder's address and enable inputs.
- Returns a one-hot acknowledge to the winning requester.

Parameters:
ROUND_ROBIN, 1, 1 = rotating priority starting after the last loaded index; 0 = fixed priority, 0 highest.

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req  input  4  request lines; bit i = requester i; held high until acked
ready  input  1  consumer accepts the current {address,enable} this cycle
address0  output  1  LSB of selected index, registered
address1  output  1  MSB of selected index, registered
enable  output  1  valid: address pair holds a pending grant, registered
ack  output  4  one-hot, combinational: ack[i] = enable & ready & ({address1,address0}==i)

Behaviour:
- Reset (async, rst_n=0): enable=0, address1/address0=00, last-pointer=3, ack=0000. Takes effect immediately, independent of clk.
- Load condition: load = !enable | ready, evaluated every cycle.
- Candidate mask: cand = req & ~ack. An index being accepted this cycle is excluded even though its req is still high at this edge.
- On a rising edge with load=1:
  - If cand != 0: register the selected index into {address1,address0}, set enable=1, and set last-pointer = selected index.
  - If cand == 0: enable=0; the address holds its previous value; last-pointer is unchanged.
- On a rising edge with load=0 (enable=1, ready=0): address, enable and pointer all hold. Changes on req, including withdrawal of the granted request, are ignored.
- Search order, ROUND_ROBIN=1: last+1, last+2, last+3, last (2-bit arithmetic, wraps mod 4).
- Search order, ROUND_ROBIN=0: 0,1,2,3; last-pointer is still maintained but unused.
- Latency: req sampled at edge N gives enable=1 after edge N (one cycle).
- Throughput: one grant per cycle while ready=1 and candidates exist.
- Requester contract: drop req at the first clock edge on which its ack is high. Re-asserting afterwards is a new request.
- ack is only ever nonzero when enable=1. It is never more than one-hot.
- ready while enable=0 has no effect beyond load=1. ack stays 0000.
- Simultaneous accept and new request: an accept cycle with another candidate present reloads back-to-back; enable stays high and the address changes.
- Reset mid-hold: the pending grant is dropped with no ack. After release the first grant is the lowest active index, because the pointer is 3.
- No X propagation: ack depends only on registered state and ready.

Decomposition:
- Shared package: NUM_REQ=4, IDX_W=2, RESET_LAST=2'd3, and an index type of IDX_W bits.
- One sub-module, rr_pick4 (purely combinational).
  - Inputs: cand[3:0], start[1:0].
  - Outputs: idx[1:0], found.
  - Fixed mode instantiates it with start=3.
- The top level holds the output/pointer registers, load logic and ack decode.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle with req=1111 -> enable=0, address=00, ack=0000 immediately.
2. Single request, ready=1: req=0100 -> one cycle later enable=1, address1/0=1/0, ack=0100. Requester drops req -> next cycle enable=0, address holds 10.
3. Full rotation: req=1111, each bit dropped on its ack, ready=1 -> grants 00,01,10,11 on four consecutive cycles, ack 0001,0010,0100,1000, then enable=0.
4. Backpressure: grant index 1 with ready=0 for 5 cycles while req toggles among 1000/0001/0000 -> address stays 01, enable=1, ack=0000. Raise ready -> ack=0010 that cycle.
5. Fairness: req0 and req3 re-asserted immediately after each ack, ready=1 -> ROUND_ROBIN=1 alternates 0,3,0,3; ROUND_ROBIN=0 grants 0 whenever req0 is present, and 3 only in the cycle req0 is masked by its own ack.
6. Reset mid-hold: enable=1, address=10, ready=0, pulse rst_n low -> enable=0 at once with no ack. With req=1010 after release -> first grant is index 1.
